sync_ram_clr: RTL and testbench

//   Parametrised single-port synchronous RAM (we/addr/data/out) with registered read
//   and a hardware clear engine that zero-fills every location after reset or on command.

---
 rtl/sync_ram_clr.sv | 122 ++++++++++++
 tb/tb_sync_ram_clr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with registered read, read-valid strobe and a zero-fill clear sweep.
// Optional even-parity storage and checking when SYNC_RAM_CLR_PARITY_EN is defined.
module sync_ram_clr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
`ifdef SYNC_RAM_CLR_PARITY_EN
    input  logic              par_inj,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

`ifdef SYNC_RAM_CLR_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [0:0]        CLEAR     = 1'b0;
    localparam logic [0:0]        IDLE      = 1'b1;
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              in_range;
    logic              accept_wr;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;

    assign busy      = (state == CLEAR);
    assign in_range  = ({1'b0, addr} < DEPTH_EXT);
    assign accept_wr = (state == IDLE) && we && in_range;

`ifdef SYNC_RAM_CLR_PARITY_EN
    // Stored parity bit is even parity of the data, optionally flipped for fault injection.
    assign wr_word = {(^data) ^ par_inj, data};
`else
    assign wr_word = data;
`endif

    // Write-first: a same-cycle write forwards the new word to the read path.
    assign rd_word = accept_wr ? wr_word : mem[addr];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = wr_word;
        if (rst_n && !clr) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = '0;
            end else if (accept_wr) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Handshake: re is accepted on an edge only when rst_n=1, clr=0 and busy=0; out_valid is
    // high for exactly the one cycle after each accepted read, with out (and parity_err) valid.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= CLEAR;
            ptr       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
`ifdef SYNC_RAM_CLR_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (state == CLEAR) begin
            out       <= '0;
            out_valid <= 1'b0;
`ifdef SYNC_RAM_CLR_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (ptr == LAST) begin
                state <= IDLE;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end else begin
            out_valid <= re;
            if (re) begin
                if (in_range) begin
                    out <= rd_word[DATA_W-1:0];
`ifdef SYNC_RAM_CLR_PARITY_EN
                    parity_err <= ^rd_word;
`endif
                end else begin
                    out <= '0;
`ifdef SYNC_RAM_CLR_PARITY_EN
                    parity_err <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_clr.sv
// Scoreboard bench for sync_ram_clr: a 64-word instance plus a 40-word instance for range checks.
module tb_sync_ram_clr;

`ifdef SYNC_RAM_CLR_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        we = 1'b0, re = 1'b0, clr = 1'b0;
    logic [5:0]  addr = '0;
    logic [15:0] data = '0;
    logic [15:0] out;
    logic        out_valid, busy;

    logic        we40 = 1'b0, re40 = 1'b0, clr40 = 1'b0;
    logic [5:0]  addr40 = '0;
    logic [15:0] data40 = '0;
    logic [15:0] out40;
    logic        out_valid40, busy40;

`ifdef SYNC_RAM_CLR_PARITY_EN
    logic par_inj = 1'b0, parity_err;
    logic par_inj40 = 1'b0, parity_err40;
`endif

    logic [16:0] exp_q[$];
    logic [16:0] exp40_q[$];
    logic [15:0] model_mem [64];
    bit          model_bad [64];
    logic [15:0] model40 [40];

    int n_cmp = 0;
    int n_bad = 0;
    int b64, b40;
    int perm [64];

    sync_ram_clr #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .data(data), .clr(clr),
`ifdef SYNC_RAM_CLR_PARITY_EN
        .par_inj(par_inj), .parity_err(parity_err),
`endif
        .out(out), .out_valid(out_valid), .busy(busy)
    );

    sync_ram_clr #(.DATA_W(16), .ADDR_W(6), .DEPTH(40)) dut40 (
        .clk(clk), .rst_n(rst_n), .we(we40), .re(re40), .addr(addr40), .data(data40), .clr(clr40),
`ifdef SYNC_RAM_CLR_PARITY_EN
        .par_inj(par_inj40), .parity_err(parity_err40),
`endif
        .out(out40), .out_valid(out_valid40), .busy(busy40)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks: one edge per call, expected read response pushed at issue time.
    task automatic op(input logic w, input logic r, input logic [5:0] a, input logic [15:0] d,
                      input logic inj);
        we = w; re = r; addr = a; data = d;
`ifdef SYNC_RAM_CLR_PARITY_EN
        par_inj = inj;
`endif
        if (w) begin
            model_mem[a] = d;
            model_bad[a] = PAR && inj;
        end
        if (r) exp_q.push_back({model_bad[a], model_mem[a]});
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
`ifdef SYNC_RAM_CLR_PARITY_EN
        par_inj = 1'b0;
`endif
    endtask

    task automatic op40(input logic w, input logic r, input logic [5:0] a, input logic [15:0] d);
        we40 = w; re40 = r; addr40 = a; data40 = d;
        if (w && a < 40) model40[a] = d;
        if (r) exp40_q.push_back({1'b0, (a < 40) ? model40[a] : 16'h0000});
        @(posedge clk); #1;
        we40 = 1'b0; re40 = 1'b0;
    endtask

    task automatic shuffle();
        int j, t;
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = '0;
            model_bad[i] = 1'b0;
        end
    endtask

    // Scoreboard monitors: pop one expectation per out_valid pulse.
    always @(negedge clk) begin
        logic [16:0] e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_valid64: got out_valid=1 out=0x%0h expected no read", out);
            end else begin
                e = exp_q.pop_front();
                check("rd_data64", {16'h0, out}, {16'h0, e[15:0]});
`ifdef SYNC_RAM_CLR_PARITY_EN
                check("parity_err64", {31'h0, parity_err}, {31'h0, e[16]});
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (out_valid40) begin
            if (exp40_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_valid40: got out_valid=1 out=0x%0h expected no read", out40);
            end else begin
                e = exp40_q.pop_front();
                check("rd_data40", {16'h0, out40}, {16'h0, e[15:0]});
`ifdef SYNC_RAM_CLR_PARITY_EN
                check("parity_err40", {31'h0, parity_err40}, {31'h0, e[16]});
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 40; i++) model40[i] = '0;
        clear_model();

        // Reset state, then length of the power-up sweep on both depths
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {16'h0, out}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_busy40", {31'h0, busy40}, 32'h1);
        rst_n = 1'b1;
        b64 = 0; b40 = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (b40 == 0 && !busy40) b40 = n;
            if (!busy) begin
                b64 = n;
                break;
            end
        end
        check("busy_len64", b64, 64);
        check("busy_len40", b40, 40);

        // Power-up contents are zero
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 6'(i), 16'h0, 1'b0);

        // Random fill, random-order readback
        for (int i = 0; i < 64; i++) op(1'b1, 1'b0, 6'(i), 16'($urandom), 1'b0);
        shuffle();
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 6'(perm[i]), 16'h0, 1'b0);

        // Mixed random traffic
        for (int i = 0; i < 150; i++)
            op(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)),
               16'($urandom), PAR ? 1'($urandom_range(1, 0)) : 1'b0);

        // Read-during-write is write-first
        op(1'b1, 1'b0, 6'd5, 16'h1234, 1'b0);
        op(1'b1, 1'b1, 6'd5, 16'hBEEF, 1'b0);
        op(1'b0, 1'b1, 6'd5, 16'h0, 1'b0);

        // Clear pulse with a read in the same cycle, reads/writes mid-sweep, restart at n=20
        op(1'b1, 1'b0, 6'd3, 16'hA5A5, 1'b0);
        op(1'b0, 1'b1, 6'd3, 16'h0, 1'b0);
        clr = 1'b1; re = 1'b1; addr = 6'd3;
        @(posedge clk); #1;
        clr = 1'b0; re = 1'b0;
        clear_model();
        check("busy_after_clr", {31'h0, busy}, 32'h1);
        check("out_zero_clr", {16'h0, out}, 32'h0);
        b64 = 0;
        for (int n = 1; n <= 300; n++) begin
            re = 1'b1; we = 1'($urandom_range(1, 0));
            addr = 6'($urandom_range(63, 0)); data = 16'($urandom);
            clr = (n == 20);
            @(posedge clk); #1;
            clr = 1'b0;
            if (n == 10) check("out_zero_sweep", {16'h0, out}, 32'h0);
            if (!busy) begin
                b64 = n;
                break;
            end
        end
        we = 1'b0; re = 1'b0;
        check("clr_restart_len", b64, 84);
        op(1'b0, 1'b1, 6'd3, 16'h0, 1'b0);
        shuffle();
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 6'(perm[i]), 16'h0, 1'b0);

`ifdef SYNC_RAM_CLR_PARITY_EN
        // Parity injection, clean rewrite, and injection on a write-first read
        op(1'b1, 1'b0, 6'd7, 16'h0001, 1'b1);
        op(1'b0, 1'b1, 6'd7, 16'h0, 1'b0);
        op(1'b1, 1'b0, 6'd7, 16'h0001, 1'b0);
        op(1'b0, 1'b1, 6'd7, 16'h0, 1'b0);
        op(1'b1, 1'b1, 6'd9, 16'h00F3, 1'b1);
`endif

        // Partial depth: out-of-range accesses are dropped and read as zero
        for (int i = 0; i < 40; i++) op40(1'b1, 1'b0, 6'(i), 16'($urandom));
        op40(1'b1, 1'b0, 6'd45, 16'hFFFF);
        op40(1'b0, 1'b1, 6'd45, 16'h0);
        op40(1'b1, 1'b1, 6'd45, 16'hFFFF);
        op40(1'b0, 1'b1, 6'd63, 16'h0);
        for (int i = 0; i < 40; i++) op40(1'b0, 1'b1, 6'(i), 16'h0);

        repeat (3) @(posedge clk);
        #1;
        check("drain64", exp_q.size(), 0);
        check("drain40", exp40_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
